// File: rtl/sar_pkg.sv
// sar_pkg: shared types, default sizes and the SAR trial-code step.
// Used by sar_bit_engine and sar_adc_ctrl_mc.
package sar_pkg;

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    localparam int NOB_DEF      = 10;
    localparam int CHANNELS_DEF = 4;

    // Resolve bit idx from the comparator, then raise the next trial bit.
    function automatic logic [31:0] next_code(input logic [31:0] code, input int idx, input logic comp);
        logic [31:0] c;
        c = code;
        if (!comp) c[idx] = 1'b0;
        if (idx > 0) c[idx-1] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_mc_if.sv
// sar_adc_ctrl_mc_if: controller bus (consumer handshake plus analog front-end).
// master: start, ch_sel, scan_en, comp_out out; sample, mux_ch, dac_code,
//         busy, digital_out, ch_out, EOC in.  slave: the mirror image.
interface sar_adc_ctrl_mc_if #(
    parameter int NOB  = 10,
    parameter int CH_W = 2
);
    logic            start;
    logic [CH_W-1:0] ch_sel;
    logic            scan_en;
    logic            comp_out;
    logic            sample;
    logic [CH_W-1:0] mux_ch;
    logic [NOB-1:0]  dac_code;
    logic            busy;
    logic [NOB-1:0]  digital_out;
    logic [CH_W-1:0] ch_out;
    logic            EOC;

    modport master (
        output start, ch_sel, scan_en, comp_out,
        input  sample, mux_ch, dac_code, busy, digital_out, ch_out, EOC
    );

    modport slave (
        input  start, ch_sel, scan_en, comp_out,
        output sample, mux_ch, dac_code, busy, digital_out, ch_out, EOC
    );

endinterface

// File: rtl/sar_bit_engine.sv
// sar_bit_engine: NOB-bit successive-approximation register with bit index.
// Ports: clk, rst (async active-low), load (start at MSB trial), step (resolve
// current bit with comp), clr (zero the code), comp; code (DAC trial code),
// nxt (code after a step), last (current bit is the LSB).
module sar_bit_engine
    import sar_pkg::*;
#(
    parameter int NOB = NOB_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic           clr,
    input  logic           comp,
    output logic [NOB-1:0] code,
    output logic [NOB-1:0] nxt,
    output logic           last
);

    localparam int IW = $clog2(NOB);
    localparam logic [NOB-1:0] MSB  = NOB'(1) << (NOB - 1);
    localparam logic [IW-1:0]  ITOP = IW'(NOB - 1);

    logic [NOB-1:0] code_q, code_d;
    logic [IW-1:0]  idx_q, idx_d;

    always_comb begin
        nxt    = NOB'(next_code(32'(code_q), int'(idx_q), comp));
        code_d = load ? MSB : clr ? '0 : step ? nxt : code_q;
        idx_d  = (load || clr) ? ITOP : (step && idx_q != '0) ? idx_q - 1'b1 : idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= '0;
            idx_q  <= ITOP;
        end else begin
            code_q <= code_d;
            idx_q  <= idx_d;
        end
    end

    assign code = code_q;
    assign last = (idx_q == '0);

endmodule

// File: rtl/sar_adc_ctrl_mc.sv
// sar_adc_ctrl_mc: multi-channel SAR ADC controller with start/busy/EOC
// handshake, programmable sampling phase and optional auto-scan.
// Ports: clk, rst (async active-low), bus (sar_adc_ctrl_mc_if.slave).
// Build option: SAR_SETTLE_EN stretches each bit slot to 1+SETTLE_CYC cycles.
module sar_adc_ctrl_mc
    import sar_pkg::*;
#(
    parameter int NOB        = NOB_DEF,
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    sar_adc_ctrl_mc_if.slave bus
);

`ifdef SAR_SETTLE_EN
    localparam int SLOT_LAST = SETTLE_CYC;
`else
    localparam int SLOT_LAST = 0;
`endif
    localparam int SC_W = $clog2(SAMPLE_CYC + 1);
    localparam int SL_W = $clog2(SETTLE_CYC + 2);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_CYC - 1);
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(SLOT_LAST);
    localparam logic [CH_W-1:0] CH_MAX  = CH_W'(CHANNELS - 1);

    state_t          state_q, state_d;
    logic            sample_q, sample_d;
    logic            busy_q, busy_d;
    logic            eoc_q, eoc_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] ch_out_q, ch_out_d;
    logic [NOB-1:0]  dout_q, dout_d;
    logic [SC_W-1:0] cnt_q, cnt_d;
    logic [SL_W-1:0] scnt_q, scnt_d;
    logic            load, step, clr, last;
    logic [NOB-1:0]  code, nxt;
    logic [CH_W-1:0] ch_clamp, ch_next;

    sar_bit_engine #(.NOB(NOB)) u_eng (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .clr  (clr),
        .comp (bus.comp_out),
        .code (code),
        .nxt  (nxt),
        .last (last)
    );

    always_comb begin
        ch_clamp = (int'(bus.ch_sel) >= CHANNELS) ? CH_MAX : bus.ch_sel;
        ch_next  = (ch_q >= CH_MAX) ? '0 : ch_q + 1'b1;
        state_d  = state_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        eoc_d    = 1'b0;
        ch_d     = ch_q;
        ch_out_d = ch_out_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        scnt_d   = scnt_q;
        load     = 1'b0;
        step     = 1'b0;
        clr      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d  = SAMPLE;
                sample_d = 1'b1;
                busy_d   = 1'b1;
                ch_d     = ch_clamp;
                cnt_d    = '0;
            end
            SAMPLE: if (cnt_q == SC_LAST) begin
                state_d  = CONVERT;
                sample_d = 1'b0;
                load     = 1'b1;
                scnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // comp_out matters only on the last edge of each bit slot
            CONVERT: if (scnt_q == SL_LAST) begin
                step   = 1'b1;
                scnt_d = '0;
                if (last) begin
                    state_d  = DONE;
                    dout_d   = nxt;
                    ch_out_d = ch_q;
                    eoc_d    = 1'b1;
                end
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
            DONE: if (bus.scan_en) begin
                state_d  = SAMPLE;
                sample_d = 1'b1;
                ch_d     = ch_next;
                cnt_d    = '0;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
                clr     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            eoc_q    <= 1'b0;
            ch_q     <= '0;
            ch_out_q <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            scnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            eoc_q    <= eoc_d;
            ch_q     <= ch_d;
            ch_out_q <= ch_out_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            scnt_q   <= scnt_d;
        end
    end

    assign bus.sample      = sample_q;
    assign bus.mux_ch      = ch_q;
    assign bus.dac_code    = code;
    assign bus.busy        = busy_q;
    assign bus.digital_out = dout_q;
    assign bus.ch_out      = ch_out_q;
    assign bus.EOC         = eoc_q;

endmodule

// File: tb/tb_sar_adc_ctrl_mc.sv
// tb_sar_adc_ctrl_mc: directed checks of sar_adc_ctrl_mc against an ideal comparator.
module tb_sar_adc_ctrl_mc;

    localparam int NOB        = 10;
    localparam int CHANNELS   = 4;
    localparam int CH_W       = 2;
    localparam int SAMPLE_CYC = 2;
`ifdef SAR_SETTLE_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int LAT = SAMPLE_CYC + NOB * (1 + SL);

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   glitch = 1'b0;
    int   vin [CHANNELS];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sar_adc_ctrl_mc_if #(.NOB(NOB), .CH_W(CH_W)) bus ();

    sar_adc_ctrl_mc #(
        .NOB        (NOB),
        .CHANNELS   (CHANNELS),
        .CH_W       (CH_W),
        .SAMPLE_CYC (SAMPLE_CYC),
        .SETTLE_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.comp_out = (int'(bus.dac_code) <= vin[bus.mux_ch]) ^ glitch;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input int ch, input int exp_code, input string tag, input int poke);
        int  k;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.ch_sel = CH_W'(ch);
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({tag, "_busy0"}, bus.busy, 1);
        check({tag, "_sample0"}, bus.sample, 1);
        k = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && k < LAT + 8) begin
            glitch = (SL > 0) && (k + 1 > SAMPLE_CYC) && ((k + 1 - SAMPLE_CYC) % (1 + SL) != 0);
            @(posedge clk);
            #1 k++;
            if (k == poke) begin
                bus.start  = 1'b1;
                bus.ch_sel = CH_W'(3);
            end
            if (poke > 0 && k == poke + 2) bus.start = 1'b0;
            if (k == SAMPLE_CYC) check({tag, "_trial0"}, bus.dac_code, 512);
            if (!bus.busy) busy_ok = 1'b0;
            seen = bus.EOC;
        end
        glitch = 1'b0;
        check({tag, "_latency"}, k, LAT);
        check({tag, "_busy_held"}, busy_ok, 1);
        check({tag, "_code"}, bus.digital_out, exp_code);
        check({tag, "_ch"}, bus.ch_out, ch);
        @(posedge clk);
        #1 check({tag, "_eoc_width"}, bus.EOC, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int exp_ch [4] = '{3, 0, 1, 2};
        int t, n, last_t;
        bus.start = 1'b0;
        bus.ch_sel = '0;
        bus.scan_en = 1'b0;
        for (int i = 0; i < CHANNELS; i++) vin[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_sample", bus.sample, 0);
        check("rst_dac", bus.dac_code, 0);
        check("rst_dout", bus.digital_out, 0);
        check("rst_eoc", bus.EOC, 0);
        check("rst_mux", bus.mux_ch, 0);
        @(negedge clk) rst = 1'b1;

        vin[2] = 512;  run_conv(2, 512, "v512", 0);
        vin[0] = 0;    run_conv(0, 0, "v0", 0);
        vin[1] = 1023; run_conv(1, 1023, "v1023", 0);
        vin[3] = 341;  run_conv(3, 341, "v341", 0);
        vin[1] = 777;  run_conv(1, 777, "ignore", 5);
`ifdef SAR_SETTLE_EN
        vin[2] = 700;  run_conv(2, 700, "settle700", 0);
`endif

        vin[0] = 100; vin[1] = 200; vin[2] = 300; vin[3] = 400;
        @(negedge clk);
        bus.scan_en = 1'b1;
        bus.start = 1'b1;
        bus.ch_sel = CH_W'(3);
        @(posedge clk);
        #1 bus.start = 1'b0;
        t = 0; n = 0; last_t = 0;
        while (n < 4 && t < 4 * (LAT + 1) + 20) begin
            @(posedge clk);
            #1 t++;
            if (n == 3 && t == last_t + 5) bus.scan_en = 1'b0;
            if (bus.EOC) begin
                check($sformatf("scan%0d_ch", n), bus.ch_out, exp_ch[n]);
                check($sformatf("scan%0d_code", n), bus.digital_out, vin[exp_ch[n]]);
                check($sformatf("scan%0d_gap", n), t - last_t, n == 0 ? LAT : LAT + 1);
                last_t = t;
                n++;
            end
        end
        check("scan_count", n, 4);
        @(posedge clk);
        #1 check("scan_stop_busy", bus.busy, 0);

        vin[0] = 600;
        @(negedge clk);
        bus.start = 1'b1;
        bus.ch_sel = '0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (SAMPLE_CYC + 4 * (1 + SL)) @(posedge clk);
        #3 check("pre_rst_dac_nonzero", int'(bus.dac_code != '0), 1);
        rst = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_sample", bus.sample, 0);
        check("arst_dac", bus.dac_code, 0);
        check("arst_dout", bus.digital_out, 0);
        check("arst_ch_out", bus.ch_out, 0);
        check("arst_mux", bus.mux_ch, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("arst_no_eoc%0d", i), bus.EOC, 0);
        end
        @(negedge clk) rst = 1'b1;
        vin[2] = 512;
        run_conv(2, 512, "post_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
